// File: rtl/rv32i_encoder_pkg.sv
// Shared definitions for the RV32I encoder: func codes, opcodes and the
// per-func format lookup used by the packer.
package rv32i_encoder_pkg;

    localparam logic [5:0]
        F_NOP  = 6'd0,  F_LUI  = 6'd1,  F_AUIPC = 6'd2,  F_JAL  = 6'd3,
        F_JALR = 6'd4,  F_BEQ  = 6'd5,  F_BNE   = 6'd6,  F_BLT  = 6'd7,
        F_BGE  = 6'd8,  F_BLTU = 6'd9,  F_BGEU  = 6'd10, F_LB   = 6'd11,
        F_LH   = 6'd12, F_LW   = 6'd13, F_LBU   = 6'd14, F_LHU  = 6'd15,
        F_SB   = 6'd16, F_SH   = 6'd17, F_SW    = 6'd18, F_ADDI = 6'd19,
        F_SLTI = 6'd20, F_SLTIU = 6'd21, F_XORI = 6'd22, F_ORI  = 6'd23,
        F_ANDI = 6'd24, F_SLLI = 6'd25, F_SRLI  = 6'd26, F_SRAI = 6'd27,
        F_ADD  = 6'd28, F_SUB  = 6'd29, F_SLL   = 6'd30, F_SLT  = 6'd31,
        F_SLTU = 6'd32, F_XOR  = 6'd33, F_SRL   = 6'd34, F_SRA  = 6'd35,
        F_OR   = 6'd36, F_AND  = 6'd37, F_LI    = 6'd38, F_BAD  = 6'd63;

    localparam logic [6:0]
        OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6F, OP_JALR = 7'h67,
        OP_BRANCH = 7'h63, OP_LOAD = 7'h03, OP_STORE = 7'h23,
        OP_IMM = 7'h13, OP_REG = 7'h33;

    localparam logic [6:0] F7_BASE = 7'h00, F7_ALT = 7'h20;
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [1:0] {ST_EMPTY, ST_SINGLE, ST_PAIR_HI} state_e;

    typedef enum logic [3:0] {
        FMT_BAD, FMT_NOP, FMT_U, FMT_J, FMT_B, FMT_I, FMT_S, FMT_SH, FMT_R, FMT_LI
    } fmt_e;

    typedef struct packed {
        fmt_e       fmt;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
    } enc_t;

    // True when v is representable as an n-bit two's-complement value.
    function automatic logic sfits(input logic [31:0] v, input int n);
        logic [31:0] m;
        m = 32'hFFFF_FFFF << (n - 1);
        return ((v & m) == 32'h0) || ((v & m) == m);
    endfunction

    function automatic enc_t enc_lookup(input logic [5:0] func);
        enc_t e;
        e = '{FMT_BAD, 7'h00, 3'd0, F7_BASE};
        case (func)
            F_NOP:   e = '{FMT_NOP, OP_IMM,    3'd0, F7_BASE};
            F_LUI:   e = '{FMT_U,   OP_LUI,    3'd0, F7_BASE};
            F_AUIPC: e = '{FMT_U,   OP_AUIPC,  3'd0, F7_BASE};
            F_JAL:   e = '{FMT_J,   OP_JAL,    3'd0, F7_BASE};
            F_JALR:  e = '{FMT_I,   OP_JALR,   3'd0, F7_BASE};
            F_BEQ:   e = '{FMT_B,   OP_BRANCH, 3'd0, F7_BASE};
            F_BNE:   e = '{FMT_B,   OP_BRANCH, 3'd1, F7_BASE};
            F_BLT:   e = '{FMT_B,   OP_BRANCH, 3'd4, F7_BASE};
            F_BGE:   e = '{FMT_B,   OP_BRANCH, 3'd5, F7_BASE};
            F_BLTU:  e = '{FMT_B,   OP_BRANCH, 3'd6, F7_BASE};
            F_BGEU:  e = '{FMT_B,   OP_BRANCH, 3'd7, F7_BASE};
            F_LB:    e = '{FMT_I,   OP_LOAD,   3'd0, F7_BASE};
            F_LH:    e = '{FMT_I,   OP_LOAD,   3'd1, F7_BASE};
            F_LW:    e = '{FMT_I,   OP_LOAD,   3'd2, F7_BASE};
            F_LBU:   e = '{FMT_I,   OP_LOAD,   3'd4, F7_BASE};
            F_LHU:   e = '{FMT_I,   OP_LOAD,   3'd5, F7_BASE};
            F_SB:    e = '{FMT_S,   OP_STORE,  3'd0, F7_BASE};
            F_SH:    e = '{FMT_S,   OP_STORE,  3'd1, F7_BASE};
            F_SW:    e = '{FMT_S,   OP_STORE,  3'd2, F7_BASE};
            F_ADDI:  e = '{FMT_I,   OP_IMM,    3'd0, F7_BASE};
            F_SLTI:  e = '{FMT_I,   OP_IMM,    3'd2, F7_BASE};
            F_SLTIU: e = '{FMT_I,   OP_IMM,    3'd3, F7_BASE};
            F_XORI:  e = '{FMT_I,   OP_IMM,    3'd4, F7_BASE};
            F_ORI:   e = '{FMT_I,   OP_IMM,    3'd6, F7_BASE};
            F_ANDI:  e = '{FMT_I,   OP_IMM,    3'd7, F7_BASE};
            F_SLLI:  e = '{FMT_SH,  OP_IMM,    3'd1, F7_BASE};
            F_SRLI:  e = '{FMT_SH,  OP_IMM,    3'd5, F7_BASE};
            F_SRAI:  e = '{FMT_SH,  OP_IMM,    3'd5, F7_ALT};
            F_ADD:   e = '{FMT_R,   OP_REG,    3'd0, F7_BASE};
            F_SUB:   e = '{FMT_R,   OP_REG,    3'd0, F7_ALT};
            F_SLL:   e = '{FMT_R,   OP_REG,    3'd1, F7_BASE};
            F_SLT:   e = '{FMT_R,   OP_REG,    3'd2, F7_BASE};
            F_SLTU:  e = '{FMT_R,   OP_REG,    3'd3, F7_BASE};
            F_XOR:   e = '{FMT_R,   OP_REG,    3'd4, F7_BASE};
            F_SRL:   e = '{FMT_R,   OP_REG,    3'd5, F7_BASE};
            F_SRA:   e = '{FMT_R,   OP_REG,    3'd5, F7_ALT};
            F_OR:    e = '{FMT_R,   OP_REG,    3'd6, F7_BASE};
            F_AND:   e = '{FMT_R,   OP_REG,    3'd7, F7_BASE};
            F_LI:    e = '{FMT_LI,  OP_LUI,    3'd0, F7_BASE};
            default: e = '{FMT_BAD, 7'h00,     3'd0, F7_BASE};
        endcase
        return e;
    endfunction

endpackage

// File: rtl/rv32i_inst_pack.sv
// Combinational RV32I field packer: places the decoded operation into its
// instruction format and reports whether the immediate is encodable.
module rv32i_inst_pack
    import rv32i_encoder_pkg::*;
(
    input  logic [5:0]  func,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rd,
    input  logic [31:0] imm,
    output logic [31:0] inst,
    output logic        imm_ok,
    output logic        is_li_pair,
    output logic [31:0] li_lo
);

    enc_t        e;
    logic [19:0] li_hi;

    assign e = enc_lookup(func);
    // Upper part of imm + 0x800: rounds so the sign-extended ADDI low half adds back exactly.
    assign li_hi = imm[31:12] + {19'd0, imm[11]};

    always_comb begin
        inst       = 32'h0;
        imm_ok     = 1'b0;
        is_li_pair = 1'b0;
        li_lo      = 32'h0;
        case (e.fmt)
            FMT_NOP: begin
                inst   = NOP_WORD;
                imm_ok = 1'b1;
            end
            FMT_U: begin
                inst   = {imm[31:12], rd, e.opc};
                imm_ok = (imm[11:0] == 12'h0);
            end
            FMT_J: begin
                inst   = {imm[20], imm[10:1], imm[11], imm[19:12], rd, e.opc};
                imm_ok = !imm[0] && sfits(imm, 21);
            end
            FMT_B: begin
                inst   = {imm[12], imm[10:5], rs2, rs1, e.f3, imm[4:1], imm[11], e.opc};
                imm_ok = !imm[0] && sfits(imm, 13);
            end
            FMT_I: begin
                inst   = {imm[11:0], rs1, e.f3, rd, e.opc};
                imm_ok = sfits(imm, 12);
            end
            FMT_S: begin
                inst   = {imm[11:5], rs2, rs1, e.f3, imm[4:0], e.opc};
                imm_ok = sfits(imm, 12);
            end
            FMT_SH: begin
                inst   = {e.f7, imm[4:0], rs1, e.f3, rd, e.opc};
                imm_ok = (imm[31:5] == 27'h0);
            end
            FMT_R: begin
                inst   = {e.f7, rs2, rs1, e.f3, rd, e.opc};
                imm_ok = 1'b1;
            end
            FMT_LI: begin
                imm_ok = 1'b1;
                if (sfits(imm, 12)) begin
                    inst = {imm[11:0], 5'd0, 3'd0, rd, OP_IMM};
                end else begin
                    inst       = {li_hi, rd, OP_LUI};
                    li_lo      = {imm[11:0], rd, 3'd0, rd, OP_IMM};
                    is_li_pair = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rv32i_encoder.sv
// Streaming RV32I encoder: handshakes decoded operations in, emits packed
// instruction words with a running address, expanding LI into LUI+ADDI.
module rv32i_encoder
    import rv32i_encoder_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int ADDR_STEP = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_func,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [4:0]        in_rd,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [ADDR_W-1:0] out_addr,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_base,
    output logic              err,
    output logic [7:0]        err_count
);

    state_e            state_q, state_d;
    logic [31:0]       inst_q, inst_d, lo_q, lo_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d, rdy_q;
    logic [7:0]        cnt_q, cnt_d;
    logic [31:0]       pk_inst, pk_lo;
    logic              pk_ok, pk_pair, acc, load_new, out_hs;

    rv32i_inst_pack u_pack (
        .func       (in_func),
        .rs1        (in_rs1),
        .rs2        (in_rs2),
        .rd         (in_rd),
        .imm        (in_imm),
        .inst       (pk_inst),
        .imm_ok     (pk_ok),
        .is_li_pair (pk_pair),
        .li_lo      (pk_lo)
    );

    assign acc      = in_valid && in_ready;
    assign load_new = acc && pk_ok;
    assign out_hs   = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_EMPTY;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY:   if (load_new) state_d = pk_pair ? ST_PAIR_HI : ST_SINGLE;
            ST_SINGLE: begin
                if (load_new)    state_d = pk_pair ? ST_PAIR_HI : ST_SINGLE;
                else if (out_hs) state_d = ST_EMPTY;
            end
            ST_PAIR_HI: if (out_hs) state_d = ST_SINGLE;
            default:    state_d = ST_EMPTY;
        endcase
    end

    // rdy_q holds off acceptance for the first cycle after reset release.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_EMPTY:   in_ready = rdy_q;
            ST_SINGLE: begin
                in_ready  = rdy_q && out_ready;
                out_valid = 1'b1;
            end
            ST_PAIR_HI: out_valid = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        inst_d = inst_q;
        lo_d   = lo_q;
        if (load_new) begin
            inst_d = pk_inst;
            lo_d   = pk_lo;
        end else if (state_q == ST_PAIR_HI && out_hs) begin
            inst_d = lo_q;
        end
        if (addr_load)   addr_d = addr_base;
        else if (out_hs) addr_d = addr_q + ADDR_W'(ADDR_STEP);
        else             addr_d = addr_q;
        err_d = acc && !pk_ok;
        cnt_d = (err_d && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_q <= 32'h0;
            lo_q   <= 32'h0;
            addr_q <= '0;
            err_q  <= 1'b0;
            cnt_q  <= 8'h0;
            rdy_q  <= 1'b0;
        end else begin
            inst_q <= inst_d;
            lo_q   <= lo_d;
            addr_q <= addr_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
            rdy_q  <= 1'b1;
        end
    end

    assign out_inst  = inst_q;
    assign out_addr  = addr_q;
    assign err       = err_q;
    assign err_count = cnt_q;

endmodule

// File: tb/tb_rv32i_encoder.sv
// Directed bench for rv32i_encoder: a table of single-word encodings plus
// hand-written sequences for LI pairs, stalls, re-addressing and reset.
module tb_rv32i_encoder;
    import rv32i_encoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [5:0]  in_func = 6'd0;
    logic [4:0]  in_rs1 = 5'd0, in_rs2 = 5'd0, in_rd = 5'd0;
    logic [31:0] in_imm = 32'd0;
    logic        out_valid, out_ready = 1'b0;
    logic [31:0] out_inst, out_addr;
    logic        addr_load = 1'b0;
    logic [31:0] addr_base = 32'd0;
    logic        err;
    logic [7:0]  err_count;

    int passed = 0;
    int total  = 0;
    logic [31:0] exp_addr;
    int          exp_errs;
    logic        seen;

    always #5 clk = ~clk;

    rv32i_encoder #(.ADDR_W(32), .ADDR_STEP(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_func(in_func),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_addr(out_addr),
        .addr_load(addr_load), .addr_base(addr_base),
        .err(err), .err_count(err_count)
    );

    typedef struct {
        logic [5:0]  f;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
        logic [31:0] exp;
        bit          bad;
    } vec_t;

    vec_t vecs[24];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    task automatic drive(input logic [5:0] f, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rd, input logic [31:0] im);
        in_func = f; in_rs1 = r1; in_rs2 = r2; in_rd = rd; in_imm = im; in_valid = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{F_ADDI,  5'd0,  5'd0,  5'd1,  32'd5,        32'h00500093, 1'b0};
        vecs[1]  = '{F_LUI,   5'd0,  5'd0,  5'd2,  32'h12345000, 32'h12345137, 1'b0};
        vecs[2]  = '{F_BEQ,   5'd1,  5'd2,  5'd0,  32'd8,        32'h00208463, 1'b0};
        vecs[3]  = '{F_NOP,   5'd0,  5'd0,  5'd0,  32'd0,        32'h00000013, 1'b0};
        vecs[4]  = '{F_JAL,   5'd0,  5'd0,  5'd1,  32'h00000800, 32'h001000EF, 1'b0};
        vecs[5]  = '{F_JAL,   5'd0,  5'd0,  5'd0,  32'hFFFFFFFE, 32'hFFFFF06F, 1'b0};
        vecs[6]  = '{F_SW,    5'd2,  5'd3,  5'd0,  32'hFFFFFFFC, 32'hFE312E23, 1'b0};
        vecs[7]  = '{F_LW,    5'd2,  5'd0,  5'd5,  32'h000007FF, 32'h7FF12283, 1'b0};
        vecs[8]  = '{F_SRAI,  5'd7,  5'd0,  5'd6,  32'd31,       32'h41F3D313, 1'b0};
        vecs[9]  = '{F_SUB,   5'd11, 5'd12, 5'd10, 32'd0,        32'h40C58533, 1'b0};
        vecs[10] = '{F_BNE,   5'd3,  5'd4,  5'd0,  32'hFFFFF000, 32'h80419063, 1'b0};
        vecs[11] = '{F_XOR,   5'd2,  5'd3,  5'd1,  32'd0,        32'h003140B3, 1'b0};
        vecs[12] = '{F_AUIPC, 5'd0,  5'd0,  5'd1,  32'hFFFFF000, 32'hFFFFF097, 1'b0};
        vecs[13] = '{F_ADDI,  5'd1,  5'd0,  5'd1,  32'hFFFFF800, 32'h80008093, 1'b0};
        vecs[14] = '{F_SRLI,  5'd2,  5'd0,  5'd1,  32'd0,        32'h00015093, 1'b0};
        vecs[15] = '{F_BEQ,   5'd1,  5'd2,  5'd0,  32'd3,        32'h0, 1'b1};
        vecs[16] = '{F_ADDI,  5'd0,  5'd0,  5'd1,  32'h00000800, 32'h0, 1'b1};
        vecs[17] = '{F_BGE,   5'd1,  5'd2,  5'd0,  32'h00001000, 32'h0, 1'b1};
        vecs[18] = '{F_LUI,   5'd0,  5'd0,  5'd2,  32'h12345001, 32'h0, 1'b1};
        vecs[19] = '{F_SLLI,  5'd1,  5'd0,  5'd1,  32'd32,       32'h0, 1'b1};
        vecs[20] = '{F_BAD,   5'd0,  5'd0,  5'd0,  32'd0,        32'h0, 1'b1};
        vecs[21] = '{6'h30,   5'd0,  5'd0,  5'd0,  32'd0,        32'h0, 1'b1};
        vecs[22] = '{F_JAL,   5'd0,  5'd0,  5'd1,  32'h00100000, 32'h0, 1'b1};
        vecs[23] = '{F_SW,    5'd2,  5'd3,  5'd0,  32'hFFFFF7FF, 32'h0, 1'b1};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_inst", out_inst, 32'd0);
        check("rst_out_addr", out_addr, 32'd0);
        check("rst_err", 32'({err, err_count}), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        addr_load = 1'b1; addr_base = 32'h100;
        @(negedge clk);
        addr_load = 1'b0;
        check("addr_load", out_addr, 32'h100);
        exp_addr = 32'h100;
        exp_errs = 0;
        out_ready = 1'b1;

        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            drive(vecs[i].f, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].imm);
            @(negedge clk);
            in_valid = 1'b0;
            if (vecs[i].bad) begin
                exp_errs++;
                check($sformatf("vec%0d_valid_err", i), 32'({out_valid, err}), 32'd1);
                check($sformatf("vec%0d_addr", i), out_addr, exp_addr);
            end else begin
                check($sformatf("vec%0d_valid_err", i), 32'({out_valid, err}), 32'd2);
                check($sformatf("vec%0d_inst", i), out_inst, vecs[i].exp);
                check($sformatf("vec%0d_addr", i), out_addr, exp_addr);
                exp_addr = exp_addr + 32'd4;
            end
        end
        @(negedge clk);
        check("table_err_count", 32'(err_count), 32'(exp_errs));

        // Back-to-back LUI then BEQ
        drive(F_LUI, 5'd0, 5'd0, 5'd2, 32'h12345000);
        @(negedge clk);
        check("b2b_lui", out_inst, 32'h12345137);
        check("b2b_lui_addr", out_addr, exp_addr);
        check("b2b_in_ready", 32'(in_ready), 32'd1);
        drive(F_BEQ, 5'd1, 5'd2, 5'd0, 32'd8);
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b_beq", out_inst, 32'h00208463);
        check("b2b_beq_addr", out_addr, exp_addr + 32'd4);
        exp_addr = exp_addr + 32'd8;

        // LI pair with output stall and re-addressing of the held word
        @(negedge clk);
        out_ready = 1'b0;
        drive(F_LI, 5'd0, 5'd0, 5'd5, 32'h12345FFF);
        @(negedge clk);
        in_valid = 1'b0;
        check("li_hi", out_inst, 32'h123462B7);
        check("li_hi_addr", out_addr, exp_addr);
        check("li_pairhi_in_ready", 32'(in_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("li_stall%0d_inst", k), out_inst, 32'h123462B7);
            check($sformatf("li_stall%0d_addr", k), out_addr, exp_addr);
        end
        addr_load = 1'b1; addr_base = 32'h200;
        @(negedge clk);
        addr_load = 1'b0;
        check("readdr_held", out_addr, 32'h200);
        check("readdr_inst", out_inst, 32'h123462B7);
        out_ready = 1'b1;
        @(negedge clk);
        check("li_lo", out_inst, 32'hFFF28293);
        check("li_lo_addr", out_addr, 32'h204);
        check("li_lo_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        check("li_done_valid", 32'(out_valid), 32'd0);
        check("li_done_addr", out_addr, 32'h208);

        // LI fitting 12 bits is one word; addr_load beats a coincident handshake
        drive(F_LI, 5'd0, 5'd0, 5'd3, 32'hFFFFFFFF);
        @(negedge clk);
        in_valid = 1'b0;
        check("li_single", out_inst, 32'hFFF00193);
        check("li_single_addr", out_addr, 32'h208);
        addr_load = 1'b1; addr_base = 32'h300;
        @(negedge clk);
        addr_load = 1'b0;
        check("li_single_valid", 32'(out_valid), 32'd0);
        check("load_wins_addr", out_addr, 32'h300);

        // Reset while in PAIR_HI discards the pending ADDI
        out_ready = 1'b0;
        drive(F_LI, 5'd0, 5'd0, 5'd5, 32'h12345FFF);
        @(negedge clk);
        in_valid = 1'b0;
        check("rst_pair_hi", out_inst, 32'h123462B7);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_valid", 32'(out_valid), 32'd0);
        check("rst_async_inst", out_inst, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("no_addi_after_rst", 32'(seen), 32'd0);
        check("rst2_addr", out_addr, 32'd0);

        // Error counter saturation
        drive(F_BAD, 5'd0, 5'd0, 5'd0, 32'd0);
        repeat (200) @(posedge clk);
        @(negedge clk);
        check("err_count_200", 32'(err_count), 32'd200);
        repeat (56) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("err_count_sat", 32'(err_count), 32'd255);
        check("err_pulse", 32'({out_valid, err}), 32'd1);
        @(negedge clk);
        check("err_drop", 32'({err, err_count}), 32'd255);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
